// File: rtl/bnn_fc_sched.sv
// bnn_fc_sched: sequences one fully connected BNN layer over a shared
// XNOR-popcount engine, one neuron at a time (fetch weights, start engine,
// collect the binarized bit), then presents the whole N_OUT-bit vector.
// Optional build macro: BNN_SCHED_TIMEOUT_EN adds an engine watchdog that
// sets a sticky o_err and substitutes a 0 bit when the engine stays silent.
//
// Handshakes: an input vector is taken when i_valid & o_ready in a cycle;
// the output vector is handed over when o_valid & i_ready in a cycle. Both
// sides may hold their valid high indefinitely; nothing is dropped.
module bnn_fc_sched #(
   parameter int N_OUT   = 256,
   parameter int ADDR_W  = 8,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_in_load,
   output logic              o_w_rd,
   output logic [ADDR_W-1:0] o_w_addr,
   output logic              o_eng_start,
   input  logic              i_eng_done,
   input  logic              i_eng_bit,
   output logic              o_valid,
   output logic [N_OUT-1:0]  o_result,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_err,
   output logic [2:0]        o_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_WAIT_RD   = 3'd2,
      S_START     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_OUT       = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);
   // WAIT_RD lasts RD_LAT-1 cycles; the counter runs 0 .. RD_LAT-2.
   localparam int RD_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
   localparam logic [RD_W-1:0] RD_LAST = RD_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] idx;
   logic [N_OUT-1:0]  result;
   logic [RD_W-1:0]   rd_cnt;
   logic              accept;
   logic              timeout_hit;
   logic              done_evt;
   logic              bit_in;

   assign accept   = (state == S_IDLE) && i_valid && rst_n;
   // A real done wins over a simultaneous watchdog expiry.
   assign done_evt = (state == S_WAIT_DONE) && (i_eng_done || timeout_hit);
   assign bit_in   = i_eng_done ? i_eng_bit : 1'b0;

`ifdef BNN_SCHED_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] to_cnt;
   logic            err;

   assign timeout_hit = (state == S_WAIT_DONE) && !i_eng_done && (to_cnt == TO_LAST);
   assign o_err       = err;

   // Watchdog: counts WAIT_DONE cycles per neuron; error flag is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (state == S_WAIT_DONE && !done_evt) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end
         if (timeout_hit) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign o_err       = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and control strobes.
   always_comb begin
      state_nx    = state;
      o_ready     = 1'b0;
      o_in_load   = 1'b0;
      o_w_rd      = 1'b0;
      o_eng_start = 1'b0;
      o_valid     = 1'b0;
      o_busy      = 1'b1;
      case (state)
         S_IDLE: begin
            o_busy    = 1'b0;
            o_ready   = rst_n;
            o_in_load = accept;
            if (accept) begin
               state_nx = S_FETCH;
            end
         end
         S_FETCH: begin
            o_w_rd   = 1'b1;
            state_nx = (RD_LAT > 1) ? S_WAIT_RD : S_START;
         end
         S_WAIT_RD: begin
            if (rd_cnt == RD_LAST) begin
               state_nx = S_START;
            end
         end
         S_START: begin
            o_eng_start = 1'b1;
            state_nx    = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (done_evt) begin
               state_nx = (idx == LAST_IDX) ? S_OUT : S_FETCH;
            end
         end
         S_OUT: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Neuron index, read-latency counter and result vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         result <= '0;
         rd_cnt <= '0;
      end else begin
         if (accept) begin
            idx    <= '0;
            result <= '0;
         end
         if (state == S_FETCH) begin
            rd_cnt <= '0;
         end else if (state == S_WAIT_RD) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (done_evt) begin
            // Neuron k lands at bit N_OUT-1-k.
            for (int k = 0; k < N_OUT; k++) begin
               if (idx == ADDR_W'(N_OUT - 1 - k)) begin
                  result[k] <= bit_in;
               end
            end
            // Index saturates at the last neuron; no wrap-around.
            if (idx != LAST_IDX) begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   assign o_w_addr = idx;
   assign o_result = result;
   assign o_state  = state;

endmodule

// File: tb/tb_bnn_fc_sched.sv
// Bench for bnn_fc_sched with N_OUT=4, RD_LAT=2, engine answering 3 cycles
// after start. Timeout scenario runs only when BNN_SCHED_TIMEOUT_EN is set.
module tb_bnn_fc_sched;

   localparam int N     = 4;
   localparam int AW    = 3;
   localparam int RL    = 2;
   localparam int TO    = 8;
   localparam int ENG_D = 3;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ready = 1'b1;
   logic          o_ready, o_in_load, o_w_rd, o_eng_start;
   logic [AW-1:0] o_w_addr;
   logic          i_eng_done, i_eng_bit;
   logic          o_valid, o_busy, o_err;
   logic [N-1:0]  o_result;
   logic [2:0]    o_state;

   logic eng_done = 1'b0, eng_bit = 1'b0;
   logic spur_done = 1'b0, spur_bit = 1'b0;
   assign i_eng_done = eng_done | spur_done;
   assign i_eng_bit  = eng_bit | spur_bit;

   bnn_fc_sched #(.N_OUT(N), .ADDR_W(AW), .RD_LAT(RL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .o_in_load(o_in_load), .o_w_rd(o_w_rd), .o_w_addr(o_w_addr),
      .o_eng_start(o_eng_start), .i_eng_done(i_eng_done), .i_eng_bit(i_eng_bit),
      .o_valid(o_valid), .o_result(o_result), .i_ready(i_ready),
      .o_busy(o_busy), .o_err(o_err), .o_state(o_state)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [N-1:0] exp_q[$];
   int           lat_q[$];
   int           eng_bits[N];
   int           silent_idx = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not seen within budget (cycle %0d)", name, cyc);
   endtask

   // expected layer vector: neuron k at bit N-1-k, silent neuron yields 0
   function automatic logic [N-1:0] exp_vec();
      logic [N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[N-1-k] = (k == silent_idx) ? 1'b0 : eng_bits[k][0];
      return v;
   endfunction

   // expected accept-to-valid cycles
   function automatic int exp_lat();
      int l;
      l = 1;
      for (int k = 0; k < N; k++) l += 2 + (RL - 1) + ((k == silent_idx) ? TO : ENG_D);
      return l;
   endfunction

   task automatic set_bits(input int b0, input int b1, input int b2, input int b3);
      eng_bits[0] = b0; eng_bits[1] = b1; eng_bits[2] = b2; eng_bits[3] = b3;
   endtask

   // engine model
   always begin : engine
      int a;
      @(negedge clk);
      if (rst_n && o_eng_start) begin
         a = int'(o_w_addr);
         if (a != silent_idx && a < N) begin
            repeat (ENG_D) @(posedge clk);
            #1 eng_done = 1'b1; eng_bit = eng_bits[a][0];
            @(posedge clk);
            #1 eng_done = 1'b0; eng_bit = 1'b0;
         end
      end
   end

   // compare process
   int           exp_idx = 0, rd_cyc = 0, rd_addr = 0, accept_cyc = 0, load_cnt = 0;
   int           last_lat = 0, acc_seen_cyc = -1;
   logic         prev_valid = 1'b0;
   logic [N-1:0] held = '0, last_result = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_idx    = 0;
         prev_valid = 1'b0;
      end else begin
         chk("ready_vs_busy", o_ready, !o_busy);
         chk("in_load", o_in_load, o_ready & i_valid);
         chk("addr_range", (int'(o_w_addr) <= N - 1), 1);
`ifndef BNN_SCHED_TIMEOUT_EN
         chk("err_tied", o_err, 0);
`endif
         if (o_in_load) load_cnt++;
         if (o_ready && i_valid) begin
            accept_cyc   = cyc;
            acc_seen_cyc = cyc;
            exp_idx      = 0;
         end
         if (o_w_rd) begin
            chk("fetch_addr", o_w_addr, exp_idx);
            exp_idx++;
            rd_cyc  = cyc;
            rd_addr = int'(o_w_addr);
         end
         if (o_eng_start) begin
            chk("start_lat", cyc - rd_cyc, RL);
            chk("start_addr", o_w_addr, rd_addr);
         end
         if (o_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               fail_msg("unexpected_valid");
            end else begin
               chk("result", o_result, exp_q.pop_front());
               chk("latency", cyc - accept_cyc, lat_q.pop_front());
            end
            held        = o_result;
            last_result = o_result;
            last_lat    = cyc - accept_cyc;
         end else if (o_valid) begin
            chk("result_hold", o_result, held);
         end
         prev_valid = o_valid;
      end
   end

   // driver tasks
   task automatic wait_accept(output int at);
      bit ok;
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_ready && i_valid) begin ok = 1'b1; at = cyc; break; end
      end
      if (!ok) fail_msg("accept");
      @(posedge clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_valid) begin ok = 1'b1; break; end
      end
      if (!ok) fail_msg("o_valid");
      #2;
   endtask

   task automatic start_layer();
      int at;
      exp_q.push_back(exp_vec());
      lat_q.push_back(exp_lat());
      @(posedge clk);
      #1 i_valid = 1'b1;
      wait_accept(at);
   endtask

   task automatic wait_start_of(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_eng_start && int'(o_w_addr) == n) begin ok = 1'b1; break; end
      end
      if (!ok) fail_msg("eng_start_wait");
   endtask

   initial begin : main
      int c0, at;
      // reset values, with i_valid high during reset
      i_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_w_rd", o_w_rd, 0);
      chk("rst_start", o_eng_start, 0);
      chk("rst_in_load", o_in_load, 0);
      chk("rst_result", o_result, 0);
      chk("rst_addr", o_w_addr, 0);
      chk("rst_err", o_err, 0);

      // layer 1: bits 1,0,1,1, accept on the first edge after release
      set_bits(1, 0, 1, 1);
      exp_q.push_back(exp_vec());
      lat_q.push_back(exp_lat());
      @(posedge clk);
      #1 rst_n = 1'b1;
      c0 = cyc;
      #1 chk("ready_after_rst", o_ready, 1);
      wait_accept(at);
      chk("first_accept_cycle", at, c0);
      wait_valid();
      chk("l1_result_lit", last_result, 4'b1011);
      chk("l1_latency_lit", last_lat, 25);
      @(posedge clk);
      #1 chk("l1_back_idle", o_ready, 1);

      // layer 2: output stall for 5 cycles
      set_bits(0, 1, 1, 0);
      i_ready = 1'b0;
      start_layer();
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", o_valid, 1);
         chk("stall_ready", o_ready, 0);
         chk("stall_result", o_result, 4'b0110);
      end
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("unstall_valid", o_valid, 0);
      chk("unstall_ready", o_ready, 1);

      // layer 3: spurious done in IDLE and in FETCH of neuron 1
      @(negedge clk);
      spur_done = 1'b1; spur_bit = 1'b1;
      @(posedge clk);
      #1 spur_done = 1'b0; spur_bit = 1'b0;
      chk("spur_idle_result", o_result, 4'b0110);
      chk("spur_idle_ready", o_ready, 1);
      set_bits(1, 0, 0, 1);
      exp_q.push_back(exp_vec());
      lat_q.push_back(exp_lat());
      @(posedge clk);
      #1 i_valid = 1'b1;
      wait_accept(at);
      begin : spur_fetch
         bit ok;
         ok = 1'b0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_w_rd && int'(o_w_addr) == 1) begin ok = 1'b1; break; end
         end
         if (!ok) fail_msg("fetch1_wait");
         spur_done = 1'b1; spur_bit = 1'b1;
         @(posedge clk);
         #1 spur_done = 1'b0; spur_bit = 1'b0;
      end
      wait_valid();
      chk("spur_result_lit", last_result, 4'b1001);

      // layer 4: reset during WAIT_DONE of neuron 2
      set_bits(1, 1, 1, 1);
      start_layer();
      wait_start_of(2);
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      lat_q.delete();
      #1;
      chk("mid_rst_valid", o_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_w_rd", o_w_rd, 0);
      chk("mid_rst_start", o_eng_start, 0);
      chk("mid_rst_in_load", o_in_load, 0);
      chk("mid_rst_result", o_result, 0);
      chk("mid_rst_addr", o_w_addr, 0);
      chk("mid_rst_err", o_err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("mid_rst_ready", o_ready, 1);
      repeat (6) @(posedge clk);
      #1;
      chk("late_done_result", o_result, 0);
      chk("late_done_ready", o_ready, 1);
      set_bits(0, 1, 0, 1);
      start_layer();
      wait_valid();
      chk("after_rst_result_lit", last_result, 4'b0101);

      // layers 5,6: i_valid held high continuously
      set_bits(1, 1, 0, 0);
      exp_q.push_back(exp_vec());
      lat_q.push_back(exp_lat());
      exp_q.push_back(exp_vec());
      lat_q.push_back(exp_lat());
      @(posedge clk);
      #1 load_cnt = 0; i_valid = 1'b1;
      wait_valid();
      wait_valid();
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("load_count", load_cnt, 2);
      chk("cont_idle", o_ready, 1);
      chk("cont_result_lit", last_result, 4'b1100);

`ifdef BNN_SCHED_TIMEOUT_EN
      // engine silent for neuron 1
      chk("err_before", o_err, 0);
      set_bits(1, 1, 1, 1);
      silent_idx = 1;
      start_layer();
      wait_valid();
      chk("to_result_lit", last_result, 4'b1011);
      chk("to_latency_lit", last_lat, 30);
      chk("to_err", o_err, 1);
      silent_idx = -1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("to_err_cleared", o_err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
`endif

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
